// File: rtl/regfile_pkg.sv
// Shared constants for the register file with pending-write scoreboard.
// Optional feature macro used by importers: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_NUM_RD   = 2;
   localparam int unsigned DEF_ZERO_REG = 1;
   localparam int unsigned ZERO_ADDR    = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, pending lookup, zero-register
// masking and, when REGFILE_BYPASS_EN is defined, same-cycle write forwarding.
// Ports:
//   raddr        read address
//   mem          whole storage array (packed, entry i at mem[i])
//   pending      pending bit per register
//   write_enable, rd, write_data, issue_valid, issue_rd
//                writeback/issue inputs, present only with REGFILE_BYPASS_EN
//   read_data    selected data
//   read_pending selected register has an outstanding producer
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG,
   localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0]             raddr,
   input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
   input  logic [DEPTH-1:0]              pending,
`ifdef REGFILE_BYPASS_EN
   input  logic                          write_enable,
   input  logic [ADDR_W-1:0]             rd,
   input  logic [DATA_W-1:0]             write_data,
   input  logic                          issue_valid,
   input  logic [ADDR_W-1:0]             issue_rd,
`endif
   output logic [DATA_W-1:0]             read_data,
   output logic                          read_pending
);

   logic is_zero;

   assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR));

   // Array lookup, optional forwarding, then zero-register masking last so it always wins.
   always_comb begin
      read_data    = mem[raddr];
      read_pending = pending[raddr];
`ifdef REGFILE_BYPASS_EN
      // A write landing this edge clears pending unless a new producer claims it on the same edge.
      if (write_enable && (rd == raddr)) begin
         read_data    = write_data;
         read_pending = issue_valid && (issue_rd == raddr);
      end
`endif
      if (is_zero) begin
         read_data    = '0;
         read_pending = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a per-register pending-write scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   write_enable, rd, write_data   writeback commit
//   issue_valid, issue_rd          mark a register as awaiting a producer
//   raddr            NUM_RD packed read addresses
//   read_data        NUM_RD packed read data (combinational)
//   read_pending     per-port pending flag (combinational)
//   any_pending      OR of all pending bits
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_enable,
   input  logic [ADDR_W-1:0]          rd,
   input  logic [DATA_W-1:0]          write_data,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_rd,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   read_data,
   output logic [NUM_RD-1:0]          read_pending,
   output logic                       any_pending
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DEPTH-1:0]             pending;
   logic                         wr_drop;
   logic                         iss_drop;

   assign wr_drop  = (ZERO_REG != 0) && (rd == ADDR_W'(ZERO_ADDR));
   assign iss_drop = (ZERO_REG != 0) && (issue_rd == ADDR_W'(ZERO_ADDR));

   // Storage and scoreboard; the issue update comes last so a same-edge issue beats the write's clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem     <= '0;
         pending <= '0;
      end else begin
         if (write_enable && !wr_drop) begin
            mem[rd]     <= write_data;
            pending[rd] <= 1'b0;
         end
         if (issue_valid && !iss_drop) begin
            pending[issue_rd] <= 1'b1;
         end
      end
   end

   assign any_pending = |pending;

   // One read port per slice of the packed address/data buses.
   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_read_port (
         .raddr        (raddr[i*ADDR_W +: ADDR_W]),
         .mem          (mem),
         .pending      (pending),
`ifdef REGFILE_BYPASS_EN
         .write_enable (write_enable),
         .rd           (rd),
         .write_data   (write_data),
         .issue_valid  (issue_valid),
         .issue_rd     (issue_rd),
`endif
         .read_data    (read_data[i*DATA_W +: DATA_W]),
         .read_pending (read_pending[i])
      );
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_regfile_scoreboard;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_RD   = 2;
   localparam int unsigned ZERO_REG = 1;
   localparam int unsigned DEPTH    = 32;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      write_enable;
   logic [ADDR_W-1:0]         rd;
   logic [DATA_W-1:0]         write_data;
   logic                      issue_valid;
   logic [ADDR_W-1:0]         issue_rd;
   logic [ADDR_W-1:0]         ra [NUM_RD];
   logic [NUM_RD*ADDR_W-1:0]  raddr;
   logic [NUM_RD*DATA_W-1:0]  read_data;
   logic [NUM_RD-1:0]         read_pending;
   logic                      any_pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] m_mem  [DEPTH];
   bit                m_pend [DEPTH];

   always #5 clk = ~clk;

   assign raddr = {ra[1], ra[0]};

   regfile_scoreboard #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .rd           (rd),
      .write_data   (write_data),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .raddr        (raddr),
      .read_data    (read_data),
      .read_pending (read_pending),
      .any_pending  (any_pending)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_zero(input int a);
      return (ZERO_REG != 0) && (a == 0);
   endfunction

   // Value a read of address a should see right now, including forwarding when enabled.
   function automatic logic [DATA_W-1:0] exp_data(input int a);
      if (is_zero(a)) return '0;
`ifdef REGFILE_BYPASS_EN
      if (!reset && write_enable && (int'(rd) == a)) return write_data;
      if (reset && write_enable && (int'(rd) == a)) return write_data;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_pend(input int a);
      if (is_zero(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (write_enable && (int'(rd) == a)) return issue_valid && (int'(issue_rd) == a);
`endif
      return m_pend[a];
   endfunction

   function automatic logic exp_any();
      logic r = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r |= m_pend[i];
      return r;
   endfunction

   task automatic drive(input logic rst, input logic we, input int wa, input logic [7:0] wd,
                        input logic iv, input int ia, input int r0, input int r1);
      reset        = rst;
      write_enable = we;
      rd           = ADDR_W'(wa);
      write_data   = wd;
      issue_valid  = iv;
      issue_rd     = ADDR_W'(ia);
      ra[0]        = ADDR_W'(r0);
      ra[1]        = ADDR_W'(r1);
   endtask

   // Compare all outputs against the model midway through the cycle.
   task automatic settle_check();
      @(negedge clk);
      for (int p = 0; p < int'(NUM_RD); p++) begin
         chk($sformatf("read_data%0d@%0d", p, ra[p]),
             32'(read_data[p*DATA_W +: DATA_W]), 32'(exp_data(int'(ra[p]))));
         chk($sformatf("read_pending%0d@%0d", p, ra[p]),
             32'(read_pending[p]), 32'(exp_pend(int'(ra[p]))));
      end
      chk("any_pending", 32'(any_pending), 32'(exp_any()));
   endtask

   // Clock edge, then apply the same edge to the model.
   task automatic edge_step();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (write_enable && !is_zero(int'(rd))) begin
            m_mem[rd]  = write_data;
            m_pend[rd] = 1'b0;
         end
         if (issue_valid && !is_zero(int'(issue_rd))) m_pend[issue_rd] = 1'b1;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_mem[i]  = 8'hxx;
         m_pend[i] = 1'b0;
      end
      drive(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 0, 0);
      edge_step();
      edge_step();

      // 1: reset state across every address
      for (int a = 0; a < int'(DEPTH); a++) begin
         drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, a, (a + 1) % int'(DEPTH));
         settle_check();
         chk("t1_data", 32'(read_data[7:0]), 32'h0);
         chk("t1_pend", 32'(read_pending), 32'h0);
         edge_step();
      end

      // 2: write then read on both ports
      drive(1'b0, 1'b1, 5, 8'hEF, 1'b0, 0, 5, 5);
      settle_check();
`ifdef REGFILE_BYPASS_EN
      chk("t2_bypass", 32'(read_data[7:0]), 32'hEF);
`else
      chk("t2_nobypass", 32'(read_data[7:0]), 32'h00);
`endif
      edge_step();
      drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 5, 5);
      settle_check();
      chk("t2_p0", 32'(read_data[7:0]), 32'hEF);
      chk("t2_p1", 32'(read_data[15:8]), 32'hEF);
      edge_step();

      // 3: issue sets pending, later write clears it
      drive(1'b0, 1'b0, 0, 8'h00, 1'b1, 7, 7, 0);
      settle_check();
      edge_step();
      drive(1'b0, 1'b1, 7, 8'h3C, 1'b0, 0, 7, 0);
      settle_check();
      chk("t3_pend", 32'(read_pending[0]), 32'(exp_pend(7)));
      chk("t3_any", 32'(any_pending), 32'h1);
      edge_step();
      drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 7, 7);
      settle_check();
      chk("t3_data", 32'(read_data[7:0]), 32'h3C);
      chk("t3_clr", 32'(read_pending[0]), 32'h0);
      edge_step();

      // 4: same-edge write and issue, newer producer wins
      drive(1'b0, 1'b1, 9, 8'hAA, 1'b1, 9, 9, 1);
      settle_check();
      edge_step();
      drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 9, 9);
      settle_check();
      chk("t4_data", 32'(read_data[7:0]), 32'hAA);
      chk("t4_pend", 32'(read_pending[0]), 32'h1);
      edge_step();

      // 5: zero register ignores write and issue
      drive(1'b0, 1'b1, 0, 8'hFF, 1'b1, 0, 0, 9);
      settle_check();
      edge_step();
      drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 0, 0);
      settle_check();
      chk("t5_data", 32'(read_data[7:0]), 32'h0);
      chk("t5_pend", 32'(read_pending[0]), 32'h0);
      chk("t5_any", 32'(any_pending), 32'h1);
      edge_step();

      // 6: reset overrides a same-edge write
      drive(1'b0, 1'b1, 3, 8'h55, 1'b1, 4, 3, 4);
      settle_check();
      edge_step();
      drive(1'b1, 1'b1, 3, 8'h11, 1'b0, 0, 3, 4);
      edge_step();
      drive(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 3, 4);
      settle_check();
      chk("t6_data", 32'(read_data[7:0]), 32'h0);
      chk("t6_any", 32'(any_pending), 32'h0);
      edge_step();

      // Randomized traffic; addresses biased toward a small window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         int wa, ia, r0, r1;
         wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         r0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 4) == 0) ? r0 : int'($urandom_range(0, 7));
         drive(($urandom_range(0, 127) == 0), 1'($urandom), wa, 8'($urandom),
               1'($urandom), ia, r0, r1);
         settle_check();
         edge_step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
